// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit while running,
// reloading on clear so a new frame always starts on a fresh bit boundary.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign bit_tick = run && (count == LAST);
  // One cycle early, so registered outputs can line up with the last cycle.
  assign pre_tick = run && (count == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO one word per frame and shifts it out as
// start, LSB-first data, optional even parity and stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 6,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic                  tx_enable,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
  logic                  parity_bit, parity_next;
  logic                  line_next;
  logic                  bit_tick, pre_tick;
  logic                  pop;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (pop),
    .run      (state != IDLE),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  // Pops are only evaluated when idle or in the final stop cycle; reset gates
  // them so a held reset never drains the FIFO.
  assign pop = !rst && tx_enable && !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_tick));
  assign fifo_read_enable = pop;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    parity_next  = parity_bit;
    line_next    = IDLE_LEVEL;

    case (state)
      IDLE: begin
        if (pop) begin
          state_next   = START;
          shift_next   = fifo_data;
          parity_next  = ^fifo_data;
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (pop) begin
            state_next   = START;
            shift_next   = fifo_data;
            parity_next  = ^fifo_data;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line is registered from the state being entered.
    case (state_next)
      START:   line_next = START_LEVEL;
      DATA:    line_next = shift_next[0];
      PARITY:  line_next = parity_next;
      STOP:    line_next = STOP_LEVEL;
      default: line_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_cnt    <= bit_cnt_next;
      parity_bit <= parity_next;
      tx_serial  <= line_next;
      tx_busy    <= (state_next != IDLE);
      frame_done <= (state == STOP) && pre_tick;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a parity instance and a no-parity instance,
// each fed from a small show-ahead FIFO model.
module tb_fifo_uart_tx;

  localparam int DW  = 6;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Parity-enabled instance and its FIFO model.
  logic [DW-1:0] mem_p [16];
  int            wr_p = 0, rd_p = 0, pops_p = 0;
  logic [DW-1:0] fifo_data_p;
  logic          fifo_empty_p, re_p, tx_enable_p, serial_p, busy_p, done_p;

  assign fifo_data_p  = mem_p[rd_p[3:0]];
  assign fifo_empty_p = (wr_p == rd_p);

  always @(posedge clk) if (re_p) begin
    rd_p   <= rd_p + 1;
    pops_p <= pops_p + 1;
  end

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .fifo_data(fifo_data_p), .fifo_empty(fifo_empty_p),
    .fifo_read_enable(re_p), .tx_enable(tx_enable_p), .tx_serial(serial_p),
    .tx_busy(busy_p), .frame_done(done_p)
  );

  // No-parity instance and its FIFO model.
  logic [DW-1:0] mem_n [16];
  int            wr_n = 0, rd_n = 0, pops_n = 0;
  logic [DW-1:0] fifo_data_n;
  logic          fifo_empty_n, re_n, tx_enable_n, serial_n, busy_n, done_n;

  assign fifo_data_n  = mem_n[rd_n[3:0]];
  assign fifo_empty_n = (wr_n == rd_n);

  always @(posedge clk) if (re_n) begin
    rd_n   <= rd_n + 1;
    pops_n <= pops_n + 1;
  end

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .fifo_data(fifo_data_n), .fifo_empty(fifo_empty_n),
    .fifo_read_enable(re_n), .tx_enable(tx_enable_n), .tx_serial(serial_n),
    .tx_busy(busy_n), .frame_done(done_n)
  );

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input logic [DW-1:0] w);
    mem_p[wr_p[3:0]] = w;
    wr_p = wr_p + 1;
  endtask

  task automatic push_n(input logic [DW-1:0] w);
    mem_n[wr_n[3:0]] = w;
    wr_n = wr_n + 1;
  endtask

  // Samples one frame of nbits bits; the line level of each bit is shifted in
  // first-bit-first, and any level change within a bit clears 'stable'.
  task automatic run_frame(input bit sel_n, input int nbits, input int drop_at,
                           output logic [15:0] bits, output bit stable,
                           output int done_at, output int done_cnt,
                           output bit busy_ok, output int re_mid,
                           output logic re_end);
    logic s, d, b, r;
    bits = '0; stable = 1'b1; done_at = 0; done_cnt = 0;
    busy_ok = 1'b1; re_mid = 0; re_end = 1'b0;
    for (int k = 1; k <= nbits * CPB; k++) begin
      tick();
      s = sel_n ? serial_n : serial_p;
      d = sel_n ? done_n   : done_p;
      b = sel_n ? busy_n   : busy_p;
      r = sel_n ? re_n     : re_p;
      if ((k - 1) % CPB == 0) bits = {bits[14:0], s};
      else if (s !== bits[0]) stable = 1'b0;
      if (d === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (b !== 1'b1) busy_ok = 1'b0;
      if (k < nbits * CPB) begin
        if (r === 1'b1) re_mid++;
      end else begin
        re_end = r;
      end
      if (k == drop_at) tx_enable_p = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_enable_p = 1'b1; tx_enable_n = 1'b1;
    tick(); tick();
    checks++; if (serial_p !== 1'b1) begin failures++; $display("FAIL rst_serial got=%b want=1", serial_p); end
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy_p); end
    checks++; if (done_p !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done_p); end
    checks++; if (re_p !== 1'b0) begin failures++; $display("FAIL rst_read_enable got=%b want=0", re_p); end
    checks++; if (serial_n !== 1'b1) begin failures++; $display("FAIL rst_serial_n got=%b want=1", serial_n); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [15:0] bits; bit stable, busy_ok; int done_at, done_cnt, re_mid; logic re_end;
    int p0;
    p0 = pops_p;
    push_p(6'h2D);
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t1_pop got=%b want=1", re_p); end
    run_frame(1'b0, 9, 0, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
    checks++; if (bits !== 16'(9'b010110101)) begin failures++; $display("FAIL t1_line got=%b want=%b", bits[8:0], 9'b010110101); end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL t1_bit_width got=%b want=1", stable); end
    checks++; if (done_at !== 36) begin failures++; $display("FAIL t1_done_cycle got=%0d want=36", done_at); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL t1_done_count got=%0d want=1", done_cnt); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b want=1", busy_ok); end
    checks++; if ((re_mid != 0) || (re_end !== 1'b0)) begin failures++; $display("FAIL t1_extra_pop got=%0d/%b want=0/0", re_mid, re_end); end
    tick();
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL t1_busy_after got=%b want=0", busy_p); end
    checks++; if (serial_p !== 1'b1) begin failures++; $display("FAIL t1_idle_line got=%b want=1", serial_p); end
    checks++; if (pops_p - p0 !== 1) begin failures++; $display("FAIL t1_pop_count got=%0d want=1", pops_p - p0); end
  endtask

  task automatic test_empty();
    int re_cnt, bad_line, bad_busy;
    re_cnt = 0; bad_line = 0; bad_busy = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (re_p !== 1'b0) re_cnt++;
      if (serial_p !== 1'b1) bad_line++;
      if (busy_p !== 1'b0) bad_busy++;
    end
    checks++; if (re_cnt != 0) begin failures++; $display("FAIL t2_read_enable got=%0d want=0", re_cnt); end
    checks++; if (bad_line != 0) begin failures++; $display("FAIL t2_line got=%0d want=0", bad_line); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL t2_busy got=%0d want=0", bad_busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits; bit stable, busy_ok; int done_at, done_cnt, re_mid; logic re_end;
    logic [8:0] exp_line [3];
    logic       exp_re_end [3];
    exp_line[0] = 9'b000000001; exp_re_end[0] = 1'b1;
    exp_line[1] = 9'b011111101; exp_re_end[1] = 1'b1;
    exp_line[2] = 9'b010101011; exp_re_end[2] = 1'b0;
    push_p(6'h00); push_p(6'h3F); push_p(6'h15);
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t3_pop0 got=%b want=1", re_p); end
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 9, 0, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
      checks++; if (bits[8:0] !== exp_line[f]) begin failures++; $display("FAIL t3_line%0d got=%b want=%b", f, bits[8:0], exp_line[f]); end
      checks++; if (stable !== 1'b1 || busy_ok !== 1'b1) begin failures++; $display("FAIL t3_gap%0d got=%b%b want=11", f, stable, busy_ok); end
      checks++; if (re_end !== exp_re_end[f] || re_mid != 0) begin failures++; $display("FAIL t3_pop_timing%0d got=%b/%0d want=%b/0", f, re_end, re_mid, exp_re_end[f]); end
      checks++; if (done_at !== 36) begin failures++; $display("FAIL t3_done%0d got=%0d want=36", f, done_at); end
    end
    tick();
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL t3_busy_after got=%b want=0", busy_p); end
  endtask

  task automatic test_enable_drop();
    logic [15:0] bits; bit stable, busy_ok; int done_at, done_cnt, re_mid; logic re_end;
    int p0, bad_line;
    push_p(6'h01); push_p(6'h3E);
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t4_pop got=%b want=1", re_p); end
    p0 = pops_p + 1;
    run_frame(1'b0, 9, 10, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
    checks++; if (bits !== 16'(9'b010000011) || stable !== 1'b1) begin failures++; $display("FAIL t4_line got=%b want=%b", bits[8:0], 9'b010000011); end
    checks++; if (done_at !== 36) begin failures++; $display("FAIL t4_done got=%0d want=36", done_at); end
    checks++; if (re_end !== 1'b0 || re_mid != 0) begin failures++; $display("FAIL t4_no_pop got=%b/%0d want=0/0", re_end, re_mid); end
    tick();
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL t4_busy_fall got=%b want=0", busy_p); end
    bad_line = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (serial_p !== 1'b1) bad_line++;
    end
    checks++; if (pops_p != p0 || bad_line != 0) begin failures++; $display("FAIL t4_held got=%0d/%0d want=%0d/0", pops_p, bad_line, p0); end
    tx_enable_p = 1'b1;
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t4_resume got=%b want=1", re_p); end
    run_frame(1'b0, 9, 0, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
    checks++; if (bits !== 16'(9'b001111111) || stable !== 1'b1) begin failures++; $display("FAIL t4_line2 got=%b want=%b", bits[8:0], 9'b001111111); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits; bit stable, busy_ok; int done_at, done_cnt, re_mid; logic re_end;
    int p0;
    push_p(6'h00); push_p(6'h2D);
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t5_pop got=%b want=1", re_p); end
    for (int k = 0; k < 20; k++) tick();
    checks++; if (serial_p !== 1'b0 || busy_p !== 1'b1) begin failures++; $display("FAIL t5_pre_reset got=%b%b want=01", serial_p, busy_p); end
    p0 = pops_p;
    rst = 1'b1;
    #1;
    checks++; if (serial_p !== 1'b1) begin failures++; $display("FAIL t5_async_line got=%b want=1", serial_p); end
    checks++; if (busy_p !== 1'b0) begin failures++; $display("FAIL t5_async_busy got=%b want=0", busy_p); end
    checks++; if (re_p !== 1'b0) begin failures++; $display("FAIL t5_gated_pop got=%b want=0", re_p); end
    tick(); tick();
    checks++; if (pops_p != p0) begin failures++; $display("FAIL t5_reset_pops got=%0d want=%0d", pops_p, p0); end
    rst = 1'b0;
    #1;
    checks++; if (re_p !== 1'b1) begin failures++; $display("FAIL t5_repop got=%b want=1", re_p); end
    run_frame(1'b0, 9, 0, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
    checks++; if (bits !== 16'(9'b010110101) || stable !== 1'b1) begin failures++; $display("FAIL t5_clean_frame got=%b want=%b", bits[8:0], 9'b010110101); end
    checks++; if (done_at !== 36) begin failures++; $display("FAIL t5_done got=%0d want=36", done_at); end
    tick();
  endtask

  task automatic test_no_parity();
    logic [15:0] bits; bit stable, busy_ok; int done_at, done_cnt, re_mid; logic re_end;
    push_n(6'h2A);
    #1;
    checks++; if (re_n !== 1'b1) begin failures++; $display("FAIL t6_pop got=%b want=1", re_n); end
    run_frame(1'b1, 8, 0, bits, stable, done_at, done_cnt, busy_ok, re_mid, re_end);
    checks++; if (bits !== 16'(8'b00101011)) begin failures++; $display("FAIL t6_line got=%b want=%b", bits[7:0], 8'b00101011); end
    checks++; if (stable !== 1'b1 || busy_ok !== 1'b1) begin failures++; $display("FAIL t6_shape got=%b%b want=11", stable, busy_ok); end
    checks++; if (done_at !== 32 || done_cnt !== 1) begin failures++; $display("FAIL t6_done got=%0d/%0d want=32/1", done_at, done_cnt); end
    tick();
    checks++; if (busy_n !== 1'b0 || serial_n !== 1'b1) begin failures++; $display("FAIL t6_idle got=%b%b want=01", busy_n, serial_n); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_empty();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_no_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
